// File: rtl/i2c_slave_rx_if.sv
// Bus-side signal bundle for the write-only I2C target: raw scl/sda in,
// open-drain pull-down request and received-byte outputs.
interface i2c_slave_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output rx_data,
        output rx_valid,
        output addr_match,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  rx_data,
        input  rx_valid,
        input  addr_match,
        input  busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples scl/sda on clk, detects START/STOP,
// matches a 7-bit address, ACKs and delivers each data byte with a strobe.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter bit         ACK_DATA   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    i2c_slave_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] shift;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // Synchronizers reset to the idle-bus level so releasing rst on a quiet
    // bus never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_in};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    // Bus conditions take priority over bit sampling; byte_done marks that the
    // 8th bit is in and the decision waits for the following scl fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= 3'd0;
            byte_done      <= 1'b0;
            shift          <= 8'h00;
            bus.sda_oe     <= 1'b0;
            bus.rx_data    <= 8'h00;
            bus.rx_valid   <= 1'b0;
            bus.addr_match <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (stop_det) begin
                state          <= IDLE;
                bit_cnt        <= 3'd0;
                byte_done      <= 1'b0;
                bus.sda_oe     <= 1'b0;
                bus.addr_match <= 1'b0;
                bus.busy       <= 1'b0;
            end else if (start_det) begin
                state          <= ADDR;
                bit_cnt        <= 3'd0;
                byte_done      <= 1'b0;
                bus.sda_oe     <= 1'b0;
                bus.addr_match <= 1'b0;
                bus.busy       <= 1'b1;
            end else begin
                case (state)
                    ADDR, DATA: begin
                        if (scl_rise && !byte_done) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            bit_cnt   <= 3'd0;
                            if (state == ADDR) begin
                                if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                                    state          <= ADDR_ACK;
                                    bus.sda_oe     <= 1'b1;
                                    bus.addr_match <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else begin
                                state        <= DATA_ACK;
                                bus.rx_data  <= shift;
                                bus.rx_valid <= 1'b1;
                                bus.sda_oe   <= ACK_DATA;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            state      <= DATA;
                            bus.sda_oe <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master on a wired-AND sda line, with
// received bytes and ACKs checked against a transaction-level model.
module tb_i2c_slave_rx;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         H          = 6;

    logic clk = 1'b0;
    logic rst;
    logic m_scl;
    logic m_sda;

    i2c_slave_rx_if bus ();

    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_slave_rx #(
        .SLAVE_ADDR(SLAVE_ADDR),
        .ACK_DATA  (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic       prev_valid = 1'b0;
    int         long_valid = 0;
    int         oe_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) rx_q.push_back(bus.rx_data);
        if (bus.rx_valid && prev_valid) long_valid++;
        prev_valid = bus.rx_valid;
        if (bus.sda_oe) oe_cnt++;
    end

    // A write addressed to us is ACKed and all its bytes delivered; anything
    // else (other address or a read) is ignored entirely.
    function automatic bit model_accepts(input logic [7:0] addr_byte);
        return (addr_byte[7:1] == SLAVE_ADDR) && (addr_byte[0] == 1'b0);
    endfunction

    task automatic wait_half();
        repeat (H) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        wait_half();
        m_scl = 1'b1;
        wait_half();
        m_sda = 1'b0;
        wait_half();
        m_scl = 1'b0;
        wait_half();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_half();
        m_scl = 1'b1;
        wait_half();
        m_sda = 1'b1;
        wait_half();
        wait_half();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        wait_half();
        m_scl = 1'b1;
        wait_half();
        m_scl = 1'b0;
        wait_half();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1;
        wait_half();
        m_scl = 1'b1;
        repeat (H / 2) @(negedge clk);
        acked = bus.sda_oe;
        repeat (H - H / 2) @(negedge clk);
        m_scl = 1'b0;
        wait_half();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.sda_oe !== 1'b0 || bus.rx_valid !== 1'b0 || bus.addr_match !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got oe=%b valid=%b match=%b busy=%b expected all 0",
                     bus.sda_oe, bus.rx_valid, bus.addr_match, bus.busy);
        end
        checks++;
        if (bus.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h expected 00", bus.rx_data);
        end
        rst = 1'b0;
        wait_half();
    endtask

    task automatic test_write_basic();
        int   base;
        logic ack;
        base = rx_q.size();
        bus_start();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy_start got %b expected 1", bus.busy);
        end
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_addr_ack got %b expected 1", ack);
        end
        checks++;
        if (bus.addr_match !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_addr_match got %b expected 1", bus.addr_match);
        end
        send_byte(8'hA5, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_data_ack got %b expected 1", ack);
        end
        bus_stop();
        checks++;
        if (bus.busy !== 1'b0 || bus.addr_match !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_after_stop got busy=%b match=%b expected 0 0", bus.busy, bus.addr_match);
        end
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL basic_rx_count got %0d expected 1", rx_q.size() - base);
        end else if (rx_q[base] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL basic_rx_data got %h expected a5", rx_q[base]);
        end
    endtask

    task automatic test_wrong_addr();
        int   base;
        int   oe0;
        logic ack;
        base = rx_q.size();
        oe0  = oe_cnt;
        bus_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b0 || bus.addr_match !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrong_addr_nack got ack=%b match=%b expected 0 0", ack, bus.addr_match);
        end
        send_byte(8'h3C, ack);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrong_addr_busy got %b expected 1", bus.busy);
        end
        bus_stop();
        checks++;
        if (oe_cnt != oe0) begin
            errors++;
            $display("[TB] FAIL wrong_addr_oe got %0d driven cycles expected 0", oe_cnt - oe0);
        end
        checks++;
        if (rx_q.size() != base) begin
            errors++;
            $display("[TB] FAIL wrong_addr_rx got %0d bytes expected 0", rx_q.size() - base);
        end
    endtask

    task automatic test_read_nack();
        int   base;
        logic ack;
        base = rx_q.size();
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_nack got %b expected 0", ack);
        end
        send_byte(8'h99, ack);
        bus_stop();
        checks++;
        if (rx_q.size() != base) begin
            errors++;
            $display("[TB] FAIL read_rx got %0d bytes expected 0", rx_q.size() - base);
        end
    endtask

    task automatic test_multi_byte();
        logic [7:0] data[3] = '{8'h01, 8'h80, 8'hFF};
        int   base;
        logic ack;
        base = rx_q.size();
        bus_start();
        send_byte(8'hA0, ack);
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i], ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("[TB] FAIL multi_ack%0d got %b expected 1", i, ack);
            end
        end
        bus_stop();
        checks++;
        if (rx_q.size() - base != 3) begin
            errors++;
            $display("[TB] FAIL multi_count got %0d expected 3", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base + i] !== data[i]) begin
                    errors++;
                    $display("[TB] FAIL multi_data%0d got %h expected %h", i, rx_q[base + i], data[i]);
                end
            end
        end
    endtask

    task automatic test_repeated_start();
        int   base;
        logic ack;
        base = rx_q.size();
        bus_start();
        send_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        bus_start();
        checks++;
        if (bus.addr_match !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstart_flags got match=%b busy=%b expected 0 1", bus.addr_match, bus.busy);
        end
        send_byte(8'hA0, ack);
        send_byte(8'h5A, ack);
        bus_stop();
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL rstart_count got %0d expected 1", rx_q.size() - base);
        end else if (rx_q[base] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rstart_data got %h expected 5a", rx_q[base]);
        end
    endtask

    task automatic test_reset_mid();
        int   base;
        logic ack;
        base = rx_q.size();
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(1'((8'hA0 >> i) & 8'h01));
        m_sda = 1'b1;
        wait_half();
        m_scl = 1'b1;
        repeat (H / 2) @(negedge clk);
        checks++;
        if (bus.sda_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre_oe got %b expected 1", bus.sda_oe);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.sda_oe !== 1'b0 || bus.rx_valid !== 1'b0 || bus.addr_match !== 1'b0 ||
            bus.busy !== 1'b0 || bus.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got oe=%b valid=%b match=%b busy=%b data=%h expected 0 0 0 0 00",
                     bus.sda_oe, bus.rx_valid, bus.addr_match, bus.busy, bus.rx_data);
        end
        repeat (2) @(negedge clk);
        m_scl = 1'b0;
        wait_half();
        m_sda = 1'b1;
        wait_half();
        m_scl = 1'b1;
        wait_half();
        rst = 1'b0;
        wait_half();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h77, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_data_ack got %b expected 1", ack);
        end
        bus_stop();
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL midrst_count got %0d expected 1", rx_q.size() - base);
        end else if (rx_q[base] !== 8'h77) begin
            errors++;
            $display("[TB] FAIL midrst_data got %h expected 77", rx_q[base]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] addr_byte;
        logic [7:0] b;
        logic       ack;
        int         base;
        int         n;
        for (int t = 0; t < 16; t++) begin
            exp_q.delete();
            base = rx_q.size();
            case ($urandom_range(0, 3))
                0, 1:    addr_byte = {SLAVE_ADDR, 1'b0};
                2:       addr_byte = {SLAVE_ADDR, 1'b1};
                default: addr_byte = 8'($urandom);
            endcase
            n = $urandom_range(1, 4);
            bus_start();
            send_byte(addr_byte, ack);
            checks++;
            if (ack !== model_accepts(addr_byte)) begin
                errors++;
                $display("[TB] FAIL rand%0d_addr_ack addr=%h got %b expected %b", t, addr_byte, ack, model_accepts(addr_byte));
            end
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_byte(b, ack);
                if (model_accepts(addr_byte)) exp_q.push_back(b);
                checks++;
                if (ack !== model_accepts(addr_byte)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_data_ack%0d got %b expected %b", t, i, ack, model_accepts(addr_byte));
                end
            end
            bus_stop();
            checks++;
            if (rx_q.size() - base != exp_q.size()) begin
                errors++;
                $display("[TB] FAIL rand%0d_count got %0d expected %0d", t, rx_q.size() - base, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (rx_q[base + i] !== exp_q[i]) begin
                        errors++;
                        $display("[TB] FAIL rand%0d_data%0d got %h expected %h", t, i, rx_q[base + i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_wrong_addr();
        test_read_nack();
        test_multi_byte();
        test_repeated_start();
        test_reset_mid();
        test_random();
        checks++;
        if (long_valid != 0) begin
            errors++;
            $display("[TB] FAIL rx_valid_width got %0d multi-cycle pulses expected 0", long_valid);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
